truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter N, default 3, number of stimulus inputs driven to the combinational unit under test (1..8).
REQ-002 Parameter DWELL, default 10, clock cycles each input vector is held before sampling (>=1).
REQ-003 Parameter GRAY, default 0, sweep order: 0 = binary count, 1 = Gray-code order.
REQ-004 The block has one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  single-cycle request to begin a sweep.
REQ-008 f  input  1  response of the unit under test to x.
REQ-009 expected  input  2^N  golden truth table; bit i = required f for x = i.
REQ-010 x  output  N  stimulus vector to the unit under test.
REQ-011 table_out  output  2^N  captured truth table; bit i = sampled f for x = i.
REQ-012 busy  output  1  high while a sweep is in progress.
REQ-013 done  output  1  one-cycle pulse at sweep end.
REQ-014 mismatch  output  1  high when table_out differs from expected, valid from done onward.
REQ-015 first_bad  output  N  lowest index i with table_out[i] != expected[i]; 0 if none.

Function
REQ-016 FSM states IDLE, RUN, FIN; IDLE->RUN on start; RUN->FIN after the last vector is sampled; FIN->IDLE unconditionally after one cycle.
REQ-017 start sampled high in IDLE: next cycle busy=1, step counter=0, dwell counter=0, table_out cleared to 0, mismatch/first_bad cleared.
REQ-018 start while busy or in FIN: ignored, no restart.
REQ-019 x = step counter when GRAY=0; x = step ^ (step>>1) when GRAY=1; x held constant for exactly DWELL cycles per step.
REQ-020 f is registered into table_out[x] on the edge ending the DWELL-th cycle of each step (settling time DWELL-1 cycles); DWELL=1 samples on the first edge.
REQ-021 Step counter increments from 0 to 2^N-1 without wrap; sampling step 2^N-1 moves to FIN.
REQ-022 Sweep length: busy high for exactly 2^N*DWELL cycles; done high in the cycle in FIN; busy low in FIN.
REQ-023 mismatch and first_bad computed from final table_out and expected, registered at entry to FIN, held until next start or reset.
REQ-024 table_out holds last sweep result in IDLE; x returns to 0 in IDLE.
REQ-025 expected is sampled only at FIN entry; changes during RUN have no effect.

Reset
REQ-026 rst_n low, any time including mid-sweep: state=IDLE, x=0, table_out=0, busy=0, done=0, mismatch=0, first_bad=0, counters=0, immediately without a clock edge.
REQ-027 After rst_n deasserts, no sweep starts until a new start pulse.

Structure
REQ-028 Shared package truth_table_pkg holds the FSM state enumeration and N/DWELL range-check constants.
REQ-029 Dwell counter width clog2(DWELL)+1; step counter width N+1 to detect terminal count.
REQ-030 One sub-module bin2gray (parametrised width N) implements the Gray mapping; instantiated, bypassed when GRAY=0.

Verification
REQ-031 N=3, DWELL=4, GRAY=0, f=x[0]^x[1]^x[2], expected=8'h96, start pulse -> x steps 0..7 every 4 cycles, busy 32 cycles, done pulse, table_out=8'h96, mismatch=0, first_bad=0.
REQ-032 Same as REQ-031 with expected=8'h97 -> table_out=8'h96, mismatch=1, first_bad=0; expected=8'hD6 -> first_bad=6.
REQ-033 N=3, DWELL=1, GRAY=1, f=x[2] -> x sequence 0,1,3,2,6,7,5,4 one cycle each, busy 8 cycles, table_out=8'hF0.
REQ-034 rst_n low at cycle 10 of a REQ-031 sweep -> all outputs 0 asynchronously; next start yields a full clean sweep, table_out=8'h96.
REQ-035 start pulsed again at cycle 5 and in the FIN cycle -> ignored; sweep length stays 32 cycles, single done pulse.
REQ-036 N=1, DWELL=2, f=~x[0], expected=2'b01 -> busy 4 cycles, table_out=2'b01, mismatch=0.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding and
// the legal ranges of the sweep parameters.
package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam int N_MIN     = 1;
    localparam int N_MAX     = 8;
    localparam int DWELL_MIN = 1;

endpackage

// File: rtl/truth_table_sweeper_bin2gray.sv
// Binary to reflected-Gray-code mapping, used to order the sweep so that
// only one stimulus bit toggles between consecutive vectors.
module bin2gray #(
    parameter int W = 3
) (
    input  logic [W-1:0] bin_i,
    output logic [W-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of a small combinational unit, captures its
// response into a truth table and compares the table against a golden one.
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int N     = 3,
    parameter int DWELL = 10,
    parameter int GRAY  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                f,
    input  logic [(1<<N)-1:0]   expected,
    output logic [N-1:0]        x,
    output logic [(1<<N)-1:0]   table_out,
    output logic                busy,
    output logic                done,
    output logic                mismatch,
    output logic [N-1:0]        first_bad
);

    localparam int TBL  = 1 << N;
    localparam int SW   = N + 1;
    localparam int DW_W = $clog2(DWELL) + 1;

    state_t          state_q;
    logic [SW-1:0]   step_q;
    logic [DW_W-1:0] dwell_q;
    logic [N-1:0]    x_q;
    logic [TBL-1:0]  table_q;
    logic            busy_q;
    logic            done_q;
    logic            mismatch_q;
    logic [N-1:0]    first_bad_q;

    logic [SW-1:0]   step_inc_s;
    logic [N-1:0]    gray_s;
    logic [N-1:0]    x_next_s;
    logic            dwell_end_s;
    logic            last_step_s;
    logic [TBL-1:0]  table_nxt_s;
    logic [TBL-1:0]  diff_s;
    logic [N-1:0]    first_bad_s;

    assign step_inc_s  = step_q + SW'(1);
    assign dwell_end_s = (dwell_q == DW_W'(DWELL - 1));
    assign last_step_s = (step_q == SW'(TBL - 1));

    bin2gray #(.W(N)) u_bin2gray (
        .bin_i  (step_inc_s[N-1:0]),
        .gray_o (gray_s)
    );

    // The Gray mapper stays instantiated; binary order simply ignores it.
    generate
        if (GRAY != 0) begin : g_gray
            assign x_next_s = gray_s;
        end else begin : g_bin
            assign x_next_s = step_inc_s[N-1:0];
        end
    endgenerate

    // Table as it will look after this cycle's sample, and its lowest differing index.
    always_comb begin
        table_nxt_s      = table_q;
        table_nxt_s[x_q] = f;
        diff_s           = table_nxt_s ^ expected;
        first_bad_s      = '0;
        for (int i = TBL - 1; i >= 0; i--) begin
            if (diff_s[i]) begin
                first_bad_s = N'(i);
            end else begin
                first_bad_s = first_bad_s;
            end
        end
    end

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            dwell_q     <= '0;
            x_q         <= '0;
            table_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
            first_bad_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    x_q    <= '0;
                    if (start) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        step_q      <= '0;
                        dwell_q     <= '0;
                        table_q     <= '0;
                        mismatch_q  <= 1'b0;
                        first_bad_q <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (dwell_end_s) begin
                        table_q <= table_nxt_s;
                        dwell_q <= '0;
                        if (last_step_s) begin
                            // expected is only looked at here, on the way into FIN.
                            state_q     <= ST_FIN;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            x_q         <= '0;
                            step_q      <= '0;
                            mismatch_q  <= |diff_s;
                            first_bad_q <= first_bad_s;
                        end else begin
                            step_q <= step_inc_s;
                            x_q    <= x_next_s;
                        end
                    end else begin
                        dwell_q <= dwell_q + DW_W'(1);
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    x_q     <= '0;
                end
            endcase
        end
    end

    assign x         = x_q;
    assign table_out = table_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign mismatch  = mismatch_q;
    assign first_bad = first_bad_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench: three sweeper configurations, vector table per sweep, scoreboard of
// expected sweep results popped on each done pulse.
module tb_truth_table_sweeper;

    typedef struct {
        logic [7:0] exp_in;
        logic [7:0] tab;
        logic       mis;
        int         fb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Config A: N=3 DWELL=4 binary, parity unit
    logic       start_a = 1'b0;
    logic [7:0] expected_a = 8'h00;
    logic [2:0] x_a, fb_a;
    logic [7:0] table_a;
    logic       busy_a, done_a, mis_a, f_a;
    assign f_a = ^x_a;
    truth_table_sweeper #(.N(3), .DWELL(4), .GRAY(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .f(f_a), .expected(expected_a),
        .x(x_a), .table_out(table_a), .busy(busy_a), .done(done_a),
        .mismatch(mis_a), .first_bad(fb_a));

    // Config B: N=3 DWELL=1 Gray, f = x[2]
    logic       start_b = 1'b0;
    logic [7:0] expected_b = 8'h00;
    logic [2:0] x_b, fb_b;
    logic [7:0] table_b;
    logic       busy_b, done_b, mis_b, f_b;
    assign f_b = x_b[2];
    truth_table_sweeper #(.N(3), .DWELL(1), .GRAY(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .f(f_b), .expected(expected_b),
        .x(x_b), .table_out(table_b), .busy(busy_b), .done(done_b),
        .mismatch(mis_b), .first_bad(fb_b));

    // Config C: N=1 DWELL=2 binary, inverter
    logic       start_c = 1'b0;
    logic [1:0] expected_c = 2'b00;
    logic [0:0] x_c, fb_c;
    logic [1:0] table_c;
    logic       busy_c, done_c, mis_c, f_c;
    assign f_c = ~x_c[0];
    truth_table_sweeper #(.N(1), .DWELL(2), .GRAY(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .f(f_c), .expected(expected_c),
        .x(x_c), .table_out(table_c), .busy(busy_c), .done(done_c),
        .mismatch(mis_c), .first_bad(fb_c));

    int         sel = 0;
    logic [7:0] x_m, table_m, fb_m;
    logic       busy_m, done_m, mis_m;

    always_comb begin
        case (sel)
            1: begin
                x_m = {5'd0, x_b}; table_m = table_b; fb_m = {5'd0, fb_b};
                busy_m = busy_b; done_m = done_b; mis_m = mis_b;
            end
            2: begin
                x_m = {7'd0, x_c}; table_m = {6'd0, table_c}; fb_m = {7'd0, fb_c};
                busy_m = busy_c; done_m = done_c; mis_m = mis_c;
            end
            default: begin
                x_m = {5'd0, x_a}; table_m = table_a; fb_m = {5'd0, fb_a};
                busy_m = busy_a; done_m = done_a; mis_m = mis_a;
            end
        endcase
    end

    int   errors = 0;
    int   checks = 0;
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        case (s)
            1:       start_b = v;
            2:       start_c = v;
            default: start_a = v;
        endcase
    endtask

    task automatic set_expected(input int s, input logic [7:0] v);
        case (s)
            1:       expected_b = v;
            2:       expected_c = v[1:0];
            default: expected_a = v;
        endcase
    endtask

    // One full sweep on config s; extra=1 also pulses start at cycle 5 and in FIN.
    task automatic sweep(input int s, input int nn, input int dw, input int gr,
                         input vec_t v, input bit extra);
        int   c;
        int   busy_cnt;
        int   done_cnt;
        int   step;
        int   xv;
        int   bound;
        bit   seen;
        vec_t r;
        sel = s;
        set_expected(s, v.exp_in);
        sb.push_back(v);
        @(negedge clk) set_start(s, 1'b1);
        @(negedge clk) set_start(s, 1'b0);
        c = 0; busy_cnt = 0; done_cnt = 0; seen = 0;
        bound = (1 << nn) * dw + 20;
        while (!seen && c < bound) begin
            if (busy_m) begin
                step = c / dw;
                xv = (gr != 0) ? (step ^ (step >> 1)) : step;
                chk($sformatf("x_c%0d", c), {24'd0, x_m}, xv);
                busy_cnt++;
            end
            if (done_m) begin
                seen = 1;
                done_cnt++;
                chk("busy_in_fin", {31'd0, busy_m}, 32'd0);
                chk("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (sb.size() > 0) begin
                    r = sb.pop_front();
                    chk("table_out", {24'd0, table_m}, {24'd0, r.tab});
                    chk("mismatch", {31'd0, mis_m}, {31'd0, r.mis});
                    chk("first_bad", {24'd0, fb_m}, r.fb);
                end
            end
            set_start(s, extra && (c == 5 || done_m));
            @(negedge clk);
            c++;
        end
        set_start(s, 1'b0);
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: no done within %0d cycles", bound);
        end
        chk("busy_len", busy_cnt, (1 << nn) * dw);
        chk("done_cnt", done_cnt, 32'd1);
        chk("post_done", {31'd0, done_m}, 32'd0);
        chk("post_busy", {31'd0, busy_m}, 32'd0);
        chk("post_x", {24'd0, x_m}, 32'd0);
        chk("post_table", {24'd0, table_m}, {24'd0, v.tab});
        @(negedge clk);
        chk("idle_busy", {31'd0, busy_m}, 32'd0);
        chk("idle_mis", {31'd0, mis_m}, {31'd0, v.mis});
    endtask

    vec_t va[5];
    vec_t vb;
    vec_t vc[2];

    initial begin
        va[0] = '{8'h96, 8'h96, 1'b0, 0};
        va[1] = '{8'h97, 8'h96, 1'b1, 0};
        va[2] = '{8'hD6, 8'h96, 1'b1, 6};
        va[3] = '{8'h16, 8'h96, 1'b1, 7};
        va[4] = '{8'h94, 8'h96, 1'b1, 1};
        vb    = '{8'hF0, 8'hF0, 1'b0, 0};
        vc[0] = '{8'h01, 8'h01, 1'b0, 0};
        vc[1] = '{8'h03, 8'h01, 1'b1, 1};

        #2;
        chk("rst_x", {29'd0, x_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_table", {24'd0, table_a}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) sweep(0, 3, 4, 0, va[i], 1'b0);
        sweep(1, 3, 1, 1, vb, 1'b0);
        for (int i = 0; i < 2; i++) sweep(2, 1, 2, 0, vc[i], 1'b0);

        // Restart attempts mid-sweep and in FIN are ignored.
        sweep(0, 3, 4, 0, va[0], 1'b1);

        // Leave a nonzero mismatch, then reset asynchronously mid-sweep.
        sweep(0, 3, 4, 0, va[2], 1'b0);
        sel = 0;
        set_expected(0, 8'h96);
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_table", {24'd0, table_a}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_x", {29'd0, x_a}, 32'd0);
        chk("arst_table", {24'd0, table_a}, 32'd0);
        chk("arst_busy", {31'd0, busy_a}, 32'd0);
        chk("arst_done", {31'd0, done_a}, 32'd0);
        chk("arst_mis", {31'd0, mis_a}, 32'd0);
        chk("arst_fb", {29'd0, fb_a}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_auto_start", {31'd0, busy_a}, 32'd0);
        sweep(0, 3, 4, 0, va[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
